// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_stage
// Brief   : RISC-V IF stage. Keeps one imem request in flight and holds one
//           stalled response in a buffer. Feeds the IF/ID register.
// Rev     : 1.0
// ============================================================================
module if_fetch_stage #(
    parameter int                  PC_W      = 9,
    parameter int                  INSTR_W   = 32,
    parameter logic [PC_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(32'h00000013)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [PC_W-1:0]    Curr_Pc_o,
    output logic [INSTR_W-1:0] Curr_Instr_o,
    output logic               valid_o
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [PC_W-1:0]    pc, pc_n;
    logic [PC_W-1:0]    req_pc, req_pc_n;
    logic               drop, drop_n;
    logic [PC_W-1:0]    buf_pc, buf_pc_n;
    logic [INSTR_W-1:0] buf_instr, buf_instr_n;
    logic [PC_W-1:0]    curr_pc, curr_pc_n;
    logic [INSTR_W-1:0] curr_instr, curr_instr_n;
    logic               valid, valid_n;
    logic               req;

    // Gated by reset so no request escapes while reset is held low.
    assign req          = reset && (state == ST_FETCH) && !redirect_i;
    assign imem_req_o   = req;
    assign imem_addr_o  = pc;
    assign Curr_Pc_o    = curr_pc;
    assign Curr_Instr_o = curr_instr;
    assign valid_o      = valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            req_pc     <= RESET_PC;
            drop       <= 1'b0;
            buf_pc     <= '0;
            buf_instr  <= NOP_INSTR;
            curr_pc    <= '0;
            curr_instr <= NOP_INSTR;
            valid      <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_pc     <= req_pc_n;
            drop       <= drop_n;
            buf_pc     <= buf_pc_n;
            buf_instr  <= buf_instr_n;
            curr_pc    <= curr_pc_n;
            curr_instr <= curr_instr_n;
            valid      <= valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_pc_n     = req_pc;
        drop_n       = drop;
        buf_pc_n     = buf_pc;
        buf_instr_n  = buf_instr;
        curr_pc_n    = curr_pc;
        curr_instr_n = curr_instr;
        valid_n      = valid;

        if (redirect_i) begin
            // Flush wins over stall; an in-flight response must be swallowed.
            valid_n      = 1'b0;
            curr_instr_n = NOP_INSTR;
            buf_pc_n     = '0;
            buf_instr_n  = NOP_INSTR;
            pc_n         = redirect_pc_i & ~PC_W'(3);
            state_n      = ST_FETCH;
            drop_n       = 1'b0;
            if (state == ST_WAIT && !imem_rvalid_i) begin
                state_n = ST_WAIT;
                drop_n  = 1'b1;
            end
        end else begin
            if (!stall_i) begin
                valid_n      = 1'b0;
                curr_instr_n = NOP_INSTR;
            end
            case (state)
                ST_FETCH: begin
                    if (req) begin
                        state_n  = ST_WAIT;
                        req_pc_n = pc;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (drop) begin
                            drop_n  = 1'b0;
                            state_n = ST_FETCH;
                        end else if (!stall_i) begin
                            curr_pc_n    = req_pc;
                            curr_instr_n = imem_rdata_i;
                            valid_n      = 1'b1;
                            pc_n         = pc + PC_W'(4);
                            state_n      = ST_FETCH;
                        end else begin
                            buf_pc_n    = req_pc;
                            buf_instr_n = imem_rdata_i;
                            pc_n        = pc + PC_W'(4);
                            state_n     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        curr_pc_n    = buf_pc;
                        curr_instr_n = buf_instr;
                        valid_n      = 1'b1;
                        state_n      = ST_FETCH;
                    end
                end
                default: state_n = ST_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// Directed bench for if_fetch_stage with a variable-latency imem model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [8:0]  curr_pc;
    logic [31:0] curr_instr;
    logic        valid;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cnt = 0;
    int overlap = 0;
    logic [8:0] mem_addr = '0;

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .Curr_Pc_o     (curr_pc),
        .Curr_Instr_o  (curr_instr),
        .valid_o       (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [8:0] a);
        case (a)
            9'h000:  return 32'h00500093;
            9'h004:  return 32'h00A00113;
            default: return {16'hC0DE, 7'h00, a};
        endcase
    endfunction

    // Instruction memory: response 'lat' cycles after the request cycle.
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (imem_req) begin
            if (cnt != 0) overlap++;
            mem_addr = imem_addr;
            cnt      = lat;
        end
        if (cnt != 0) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_data(mem_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [8:0] pc,
                              input logic [31:0] instr);
        check({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
        check({tag, "_pc"}, {23'd0, curr_pc}, {23'd0, pc});
        check({tag, "_instr"}, curr_instr, instr);
    endtask

    task automatic check_req(input string tag, input logic r, input logic [8:0] a);
        check({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
        if (r) check({tag, "_addr"}, {23'd0, imem_addr}, {23'd0, a});
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check_ifid("rst", 1'b0, 9'h000, NOP);
        check_req("rst", 1'b0, 9'h000);
        reset = 1'b1;
        #1 check_req("first", 1'b1, 9'h000);

        // 1-cycle memory, back-to-back fetch
        @(negedge clk);
        check_req("wait0", 1'b0, 9'h000);
        check_ifid("wait0", 1'b0, 9'h000, NOP);
        @(negedge clk);
        check_ifid("i0", 1'b1, 9'h000, 32'h00500093);
        check_req("i0", 1'b1, 9'h004);
        @(negedge clk);
        check_ifid("bub0", 1'b0, 9'h000, NOP);
        @(negedge clk);
        check_ifid("i1", 1'b1, 9'h004, 32'h00A00113);
        check_req("i1", 1'b1, 9'h008);

        // Stall across the response of 0x008
        stall = 1'b1;
        @(negedge clk);
        check_ifid("stl0", 1'b1, 9'h004, 32'h00A00113);
        @(negedge clk);
        check_ifid("stl1", 1'b1, 9'h004, 32'h00A00113);
        check_req("stl1", 1'b0, 9'h000);
        @(negedge clk);
        check_ifid("hold", 1'b1, 9'h004, 32'h00A00113);
        check_req("hold", 1'b0, 9'h000);
        stall = 1'b0;
        @(negedge clk);
        check_ifid("unhold", 1'b1, 9'h008, 32'hC0DE0008);
        check_req("unhold", 1'b1, 9'h00C);
        @(negedge clk);
        lat = 3;
        @(negedge clk);
        check_ifid("i3", 1'b1, 9'h00C, 32'hC0DE000C);
        check_req("i3", 1'b1, 9'h010);

        // Redirect while waiting on 0x010 (3-cycle latency)
        @(negedge clk);
        check_req("w10", 1'b0, 9'h000);
        redirect = 1'b1;
        redirect_pc = 9'h040;
        @(negedge clk);
        redirect = 1'b0;
        lat = 1;
        check_ifid("flush", 1'b0, 9'h00C, NOP);
        check_req("drop0", 1'b0, 9'h000);
        @(negedge clk);
        check_req("drop1", 1'b0, 9'h000);
        @(negedge clk);
        check_ifid("dropped", 1'b0, 9'h00C, NOP);
        check_req("tgt40", 1'b1, 9'h040);

        // Redirect coinciding with rvalid under stall, unaligned target
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 9'h043;
        stall = 1'b1;
        @(negedge clk);
        check_ifid("rdrv", 1'b0, 9'h00C, NOP);
        redirect = 1'b0;
        stall = 1'b0;
        #1 check_req("rdrv", 1'b1, 9'h040);
        @(negedge clk);
        @(negedge clk);
        check_ifid("i40", 1'b1, 9'h040, 32'hC0DE0040);
        check_req("i40", 1'b1, 9'h044);

        // PC wrap at 0x1FC
        redirect = 1'b1;
        redirect_pc = 9'h1FC;
        @(negedge clk);
        redirect = 1'b0;
        check_ifid("r1fc", 1'b0, 9'h040, NOP);
        #1 check_req("r1fc", 1'b1, 9'h1FC);
        @(negedge clk);
        @(negedge clk);
        check_ifid("i1fc", 1'b1, 9'h1FC, 32'hC0DE01FC);
        check_req("wrap", 1'b1, 9'h000);
        lat = 3;

        // Reset during WAIT; late response arrives in FETCH
        @(negedge clk);
        check_req("rw", 1'b0, 9'h000);
        reset = 1'b0;
        #1 check_ifid("rstw", 1'b0, 9'h000, NOP);
        check_req("rstw", 1'b0, 9'h000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        lat = 1;
        #1 check_req("late", 1'b1, 9'h000);
        check({"late_rvalid"}, {31'd0, imem_rvalid}, 32'd1);
        @(negedge clk);
        check_ifid("lateign", 1'b0, 9'h000, NOP);
        @(negedge clk);
        check_ifid("pr0", 1'b1, 9'h000, 32'h00500093);
        check_req("pr0", 1'b1, 9'h004);

        // Reset during HOLD
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_req("h2", 1'b0, 9'h000);
        check_ifid("h2", 1'b1, 9'h000, 32'h00500093);
        reset = 1'b0;
        #1 check_ifid("rsth", 1'b0, 9'h000, NOP);
        check_req("rsth", 1'b0, 9'h000);
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        #1 check_req("ph", 1'b1, 9'h000);
        @(negedge clk);
        check_ifid("phbuf", 1'b0, 9'h000, NOP);
        @(negedge clk);
        check_ifid("ph0", 1'b1, 9'h000, 32'h00500093);
        check_req("ph0", 1'b1, 9'h004);

        check("overlap", overlap, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
